// File: rtl/exp_sched.sv
// Round-robin scheduler that shares one x^n mod 2^W engine among NREQ requesters.
// Trivial exponents (0 and 1) are answered locally; a cycle timeout guards against a hung engine.
module exp_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_x,
    input  logic [NREQ*W-1:0]       req_n,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [W-1:0]            rsp_data,
    output logic                    eng_start,
    output logic [W-1:0]            eng_x,
    output logic [W-1:0]            eng_n,
    input  logic                    eng_done,
    input  logic [W-1:0]            eng_res,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [GW-1:0] w_win;
    logic [GW-1:0] w_idx;
    logic          w_found;
    logic          w_xfer;
    logic          w_timeout;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_res;
    logic [W-1:0]  w_selX;
    logic [W-1:0]  w_selN;
    logic [CW-1:0] r_cnt;
    logic          r_timeoutErr;

    // Search starts just after the most recently retired channel.
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = GW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_selX    = req_x[int'(w_win)*W +: W];
    assign w_selN    = req_n[int'(w_win)*W +: W];
    assign w_xfer    = (r_state == S_IDLE) && w_found;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready = NREQ'(1) << w_win;
                    w_next    = (w_selN <= W'(1)) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = NREQ'(1) << r_grant;
                if (rsp_ready[r_grant]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A completion in the final timeout cycle still delivers the engine result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant      <= '0;
            r_last       <= GW'(NREQ - 1);
            r_x          <= '0;
            r_n          <= '0;
            r_res        <= '0;
            r_cnt        <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_grant <= w_win;
                        r_x     <= w_selX;
                        r_n     <= w_selN;
                        if (w_selN == '0) begin
                            r_res <= W'(1);
                        end else if (w_selN == W'(1)) begin
                            r_res <= w_selX;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (eng_done) begin
                        r_res <= eng_res;
                    end else if (w_timeout) begin
                        r_res        <= '0;
                        r_timeoutErr <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_grant]) begin
                        r_last <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data    = r_res;
    assign eng_x       = r_x;
    assign eng_n       = r_n;
    assign grant_id    = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_exp_sched.sv
// Scoreboard bench for exp_sched: a behavioural engine answers launches, a round-robin model
// predicts each grant and its result, and responses are popped and compared on handshake.
module tb_exp_sched;
    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } sbEntry_t;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_n;
    logic [NREQ-1:0]  rsp_valid;
    logic [NREQ-1:0]  rsp_ready;
    logic [W-1:0]     rsp_data;
    logic             eng_start;
    logic [W-1:0]     eng_x;
    logic [W-1:0]     eng_n;
    logic             eng_done;
    logic [W-1:0]     eng_res;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;
    int acceptCount = 0;
    int rspCount    = 0;
    int acceptCyc   = 0;
    int rspRiseCyc  = 0;
    int doneCyc     = 0;
    int lastAcceptCh = -1;
    int modelLast   = NREQ - 1;
    bit prevRsp     = 1'b0;
    logic [31:0] lastRspData  = '0;
    logic [3:0]  lastRspValid = '0;
    int          grantLog[$];
    sbEntry_t    sb[$];

    int          engDelay     = 4;
    bit          engHang      = 1'b0;
    bit          engForceDone = 1'b0;
    logic        engDoneModel = 1'b0;
    logic [31:0] engResModel  = '0;
    int          engLeft      = 0;
    bit          engBusy      = 1'b0;
    int          engStarts    = 0;
    logic [31:0] engX         = '0;
    logic [31:0] engN         = '0;

    exp_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_n       (req_n),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_n       (eng_n),
        .eng_done    (eng_done),
        .eng_res     (eng_res),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] modelPow(input logic [31:0] x, input logic [31:0] n);
        logic [31:0] r;
        logic [31:0] b;
        r = 32'd1;
        b = x;
        for (int i = 0; i < 32; i++) begin
            if (n[i]) r = r * b;
            b = b * b;
        end
        return r;
    endfunction

    assign eng_done = engDoneModel | engForceDone;
    assign eng_res  = engForceDone ? 32'hDEAD_BEEF : engResModel;

    // Behavioural engine: answers engDelay cycles after a launch unless told to hang.
    always @(negedge clk) begin
        engDoneModel = 1'b0;
        if (!rst) begin
            engBusy = 1'b0;
        end else if (engBusy) begin
            engLeft--;
            if (engLeft <= 0) begin
                engDoneModel = 1'b1;
                engResModel  = modelPow(engX, engN);
                engBusy      = 1'b0;
            end
        end else if (eng_start) begin
            engStarts++;
            if (!engHang) begin
                engBusy = 1'b1;
                engLeft = engDelay;
                engX    = eng_x;
                engN    = eng_n;
            end
        end
    end

    task automatic monitor();
        sbEntry_t e;
        int expWin;
        int idx;
        int actWin;
        if (eng_done) doneCyc = cycle;
        if (rsp_valid != 0 && !prevRsp) rspRiseCyc = cycle;
        prevRsp = (rsp_valid != 0);
        if (req_ready != 0) begin
            expWin = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (modelLast + k) % NREQ;
                if (expWin < 0 && req_valid[idx]) expWin = idx;
            end
            actWin = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) actWin = i;
            assertCount++;
            if (expWin < 0) begin
                failCount++;
                $display("[TB] FAIL arbitration: req_ready=%b with no valid request", req_ready);
            end else begin
                if (req_ready !== (4'b0001 << expWin)) begin
                    failCount++;
                    $display("[TB] FAIL arbitration: req_ready=%b, required winner %0d", req_ready, expWin);
                end
                e.ch   = expWin;
                e.data = engHang ? 32'd0 : modelPow(req_x[expWin*W +: W], req_n[expWin*W +: W]);
                sb.push_back(e);
            end
            grantLog.push_back(actWin);
            lastAcceptCh = actWin;
            acceptCyc    = cycle;
            acceptCount++;
        end
        if ((rsp_valid & rsp_ready) != 0) begin
            assertCount++;
            if (sb.size() == 0) begin
                failCount++;
                $display("[TB] FAIL response: rsp_valid=%b data=%0d with empty scoreboard", rsp_valid, rsp_data);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== (4'b0001 << e.ch) || rsp_data !== e.data) begin
                    failCount++;
                    $display("[TB] FAIL response: rsp_valid=%b data=%0d, required ch %0d data %0d",
                             rsp_valid, rsp_data, e.ch, e.data);
                end
                modelLast = e.ch;
            end
            lastRspData  = rsp_data;
            lastRspValid = rsp_valid;
            rspCount++;
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(negedge clk);
        cycle++;
    endtask

    task automatic setReq(input int ch, input logic [31:0] x, input logic [31:0] n);
        req_x[ch*W +: W] = x;
        req_n[ch*W +: W] = n;
    endtask

    task automatic waitAccept(input int maxCyc, output bit ok);
        int start;
        start = acceptCount;
        ok = 1'b0;
        for (int i = 0; i < maxCyc && !ok; i++) begin
            tick();
            if (acceptCount != start) ok = 1'b1;
        end
    endtask

    task automatic waitRsp(input int target, input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCyc && !ok; i++) begin
            tick();
            if (rspCount >= target) ok = 1'b1;
        end
    endtask

    task automatic doReset();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        modelLast = NREQ - 1;
        prevRsp   = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        assertCount++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || eng_start !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_ctrl: busy=%b rsp_valid=%b eng_start=%b, required 0/0000/0", busy, rsp_valid, eng_start);
        end
        assertCount++;
        if (timeout_err !== 1'b0 || grant_id !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL reset_status: timeout_err=%b grant_id=%0d, required 0/0", timeout_err, grant_id);
        end
        assertCount++;
        if (eng_x !== 32'd0 || eng_n !== 32'd0 || rsp_data !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL reset_data: eng_x=%0d eng_n=%0d rsp_data=%0d, required 0", eng_x, eng_n, rsp_data);
        end
        assertCount++;
        if (req_ready !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_ready: req_ready=%b, required 0000", req_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        int starts0;
        starts0   = engStarts;
        engDelay  = 6;
        rsp_ready = 4'b0001;
        setReq(0, 32'd3, 32'd5);
        req_valid = 4'b0001;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        assertCount++;
        if (!ok) begin failCount++; $display("[TB] FAIL single_accept: no accept, required accept within 10 cycles"); end
        assertCount++;
        if (eng_start !== 1'b1 || eng_x !== 32'd3 || eng_n !== 32'd5 || grant_id !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL single_issue: start=%b x=%0d n=%0d gid=%0d, required 1/3/5/0", eng_start, eng_x, eng_n, grant_id);
        end
        waitRsp(rspCount + 1, 40, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd243 || lastRspValid !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL single_result: ok=%b data=%0d valid=%b, required 1/243/0001", ok, lastRspData, lastRspValid);
        end
        assertCount++;
        if (doneCyc - acceptCyc != 7 || rspRiseCyc != doneCyc + 1) begin
            failCount++;
            $display("[TB] FAIL single_latency: done-accept=%0d rsp-done=%0d, required 7/1", doneCyc - acceptCyc, rspRiseCyc - doneCyc);
        end
        assertCount++;
        if (engStarts - starts0 != 1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_starts: starts=%0d busy=%b, required 1/0", engStarts - starts0, busy);
        end
    endtask

    task automatic test_bypass();
        bit ok;
        int starts0;
        starts0   = engStarts;
        rsp_ready = 4'b0100;
        setReq(2, 32'd9, 32'd0);
        req_valid = 4'b0100;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        waitRsp(rspCount + 1, 10, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd1 || rspRiseCyc != acceptCyc + 1) begin
            failCount++;
            $display("[TB] FAIL bypass_n0: ok=%b data=%0d lat=%0d, required 1/1/1", ok, lastRspData, rspRiseCyc - acceptCyc);
        end
        setReq(2, 32'd7, 32'd1);
        req_valid = 4'b0100;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        waitRsp(rspCount + 1, 10, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd7 || rspRiseCyc != acceptCyc + 1) begin
            failCount++;
            $display("[TB] FAIL bypass_n1: ok=%b data=%0d lat=%0d, required 1/7/1", ok, lastRspData, rspRiseCyc - acceptCyc);
        end
        assertCount++;
        if (engStarts != starts0) begin
            failCount++;
            $display("[TB] FAIL bypass_nostart: starts=%0d, required 0", engStarts - starts0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int a0;
        int r0;
        int g0;
        int expOrder[5] = '{0, 1, 2, 3, 0};
        doReset();
        engDelay  = 3;
        rsp_ready = 4'b1111;
        for (int i = 0; i < NREQ; i++) setReq(i, 32'd2, 32'(i + 2));
        a0 = acceptCount;
        r0 = rspCount;
        g0 = grantLog.size();
        req_valid = 4'b1111;
        for (int i = 0; i < 200 && acceptCount - a0 < 5; i++) tick();
        req_valid = 4'b0000;
        waitRsp(r0 + 5, 60, ok);
        assertCount++;
        if (acceptCount - a0 != 5 || !ok) begin
            failCount++;
            $display("[TB] FAIL fair_count: accepts=%0d rsps=%0d, required 5/5", acceptCount - a0, rspCount - r0);
        end else begin
            for (int j = 0; j < 5; j++) begin
                assertCount++;
                if (grantLog[g0 + j] != expOrder[j]) begin
                    failCount++;
                    $display("[TB] FAIL fair_order[%0d]: grant=%0d, required %0d", j, grantLog[g0 + j], expOrder[j]);
                end
            end
        end
        assertCount++;
        if (lastRspData !== 32'd4) begin
            failCount++;
            $display("[TB] FAIL fair_last: data=%0d, required 4", lastRspData);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int r0;
        engDelay  = 2;
        rsp_ready = 4'b0000;
        for (int i = 0; i < NREQ; i++) setReq(i, 32'd5, 32'd3);
        req_valid = 4'b1111;
        waitAccept(10, ok);
        r0 = rspCount;
        assertCount++;
        if (!ok || lastAcceptCh != 1) begin
            failCount++;
            $display("[TB] FAIL bp_grant: ok=%b ch=%0d, required 1/1", ok, lastAcceptCh);
        end
        for (int i = 0; i < 30 && rsp_valid == 4'b0000; i++) tick();
        rsp_ready = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            tick();
            assertCount++;
            if (rsp_valid !== 4'b0010 || rsp_data !== 32'd125 || req_ready !== 4'b0000) begin
                failCount++;
                $display("[TB] FAIL bp_hold[%0d]: valid=%b data=%0d ready=%b, required 0010/125/0000",
                         i, rsp_valid, rsp_data, req_ready);
            end
        end
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        waitRsp(r0 + 1, 5, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd125) begin
            failCount++;
            $display("[TB] FAIL bp_release: ok=%b data=%0d, required 1/125", ok, lastRspData);
        end
    endtask

    task automatic test_timeout_boundary();
        bit ok;
        engDelay  = TIMEOUT;
        rsp_ready = 4'b1111;
        setReq(2, 32'd3, 32'd4);
        req_valid = 4'b0100;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        waitRsp(rspCount + 1, 40, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd81 || timeout_err !== 1'b0 || rspRiseCyc - acceptCyc != TIMEOUT + 2) begin
            failCount++;
            $display("[TB] FAIL done_at_limit: ok=%b data=%0d terr=%b lat=%0d, required 1/81/0/%0d",
                     ok, lastRspData, timeout_err, rspRiseCyc - acceptCyc, TIMEOUT + 2);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        engHang   = 1'b1;
        rsp_ready = 4'b1111;
        setReq(3, 32'd3, 32'd4);
        req_valid = 4'b1000;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        assertCount++;
        if (!ok || timeout_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_pre: ok=%b terr=%b, required 1/0", ok, timeout_err);
        end
        waitRsp(rspCount + 1, 40, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd0 || timeout_err !== 1'b1 || rspRiseCyc - acceptCyc != TIMEOUT + 2) begin
            failCount++;
            $display("[TB] FAIL timeout_abort: ok=%b data=%0d terr=%b lat=%0d, required 1/0/1/%0d",
                     ok, lastRspData, timeout_err, rspRiseCyc - acceptCyc, TIMEOUT + 2);
        end
        engHang  = 1'b0;
        engDelay = 4;
        setReq(0, 32'd2, 32'd10);
        req_valid = 4'b0001;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        waitRsp(rspCount + 1, 40, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd1024 || timeout_err !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL timeout_sticky: ok=%b data=%0d terr=%b, required 1/1024/1", ok, lastRspData, timeout_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        engHang   = 1'b1;
        rsp_ready = 4'b1111;
        setReq(1, 32'd5, 32'd2);
        req_valid = 4'b0010;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        repeat (4) tick();
        assertCount++;
        if (!ok || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midreset_pre: ok=%b busy=%b, required 1/1", ok, busy);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb.delete();
        modelLast = NREQ - 1;
        prevRsp   = 1'b0;
        assertCount++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || timeout_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midreset_clear: busy=%b valid=%b terr=%b, required 0/0000/0", busy, rsp_valid, timeout_err);
        end
        engForceDone = 1'b1;
        tick();
        engForceDone = 1'b0;
        repeat (3) tick();
        assertCount++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL late_done: busy=%b valid=%b, required 0/0000", busy, rsp_valid);
        end
        engHang  = 1'b0;
        engDelay = 2;
        for (int i = 0; i < NREQ; i++) setReq(i, 32'(i + 2), 32'd2);
        req_valid = 4'b1111;
        waitAccept(10, ok);
        req_valid = 4'b0000;
        assertCount++;
        if (!ok || lastAcceptCh != 0) begin
            failCount++;
            $display("[TB] FAIL midreset_prio: ok=%b ch=%0d, required 1/0", ok, lastAcceptCh);
        end
        waitRsp(rspCount + 1, 20, ok);
        assertCount++;
        if (!ok || lastRspData !== 32'd4) begin
            failCount++;
            $display("[TB] FAIL midreset_job: ok=%b data=%0d, required 1/4", ok, lastRspData);
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_n     = '0;
        rsp_ready = '0;
        test_reset();
        test_single();
        test_bypass();
        test_back_to_back();
        test_backpressure();
        test_timeout_boundary();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
